// File: rtl/vga_timing_gen_if.sv
// vga_if: pixel-stream bundle shared by the timing generator and the draw stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport vga_in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counter and sync/blank generator at the head of the video pipeline.
// Optional macro VGA_FRAME_CNT_EN enables the 16-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    vga_if.vga_out      vga_out,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Thresholds are 12 bits wide so that a sync ending exactly at 2048 still compares correctly.
    localparam logic [11:0] H_BLANK_AT  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_AT   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_BLANK_AT  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_AT   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END  = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        h_wrap;
    logic        v_wrap;
    logic        fs_next;
    logic        hblnk_next;
    logic        vblnk_next;
    logic        hsync_on;
    logic        vsync_on;

    // Next raster position and the flags it implies, so flags register alongside the counters.
    always_comb begin
        h_wrap     = (hcount == H_LAST);
        v_wrap     = (vcount == V_LAST);
        h_next     = h_wrap ? '0 : hcount + 11'd1;
        v_next     = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : vcount + 11'd1;
        end
        fs_next    = h_wrap && v_wrap;
        hblnk_next = ({1'b0, h_next} >= H_BLANK_AT);
        vblnk_next = ({1'b0, v_next} >= V_BLANK_AT);
        hsync_on   = ({1'b0, h_next} >= H_SYNC_AT) && ({1'b0, h_next} < H_SYNC_END);
        vsync_on   = ({1'b0, v_next} >= V_SYNC_AT) && ({1'b0, v_next} < V_SYNC_END);
    end

    // Raster registers: advance on en, hold otherwise; frame_start only lives for one advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else if (en) begin
            hcount      <= h_next;
            vcount      <= v_next;
            hblnk       <= hblnk_next;
            vblnk       <= vblnk_next;
            hsync       <= hsync_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= vsync_on ? SYNC_POL : ~SYNC_POL;
            rgb         <= '0;
            frame_start <= fs_next;
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Count frames in step with frame_start so the new value appears with the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (en && fs_next) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

    assign vga_out.hcount = hcount;
    assign vga_out.vcount = vcount;
    assign vga_out.hsync  = hsync;
    assign vga_out.vsync  = vsync;
    assign vga_out.hblnk  = hblnk;
    assign vga_out.vblnk  = vblnk;
    assign vga_out.rgb    = rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced 32x16 raster,
// with an active-high and an active-low sync instance running side by side.
module tb_vga_timing_gen;

    // Reduced timing: 16+4+6+6 = 32 pixels per line, 10+1+2+3 = 16 lines per frame.
    localparam int HT        = 32;
    localparam int VT        = 16;
    localparam int HB_FIRST  = 16;
    localparam int HS_FIRST  = 20;
    localparam int HS_LAST   = 25;
    localparam int VB_FIRST  = 10;
    localparam int VS_FIRST  = 11;
    localparam int VS_LAST   = 12;
    localparam int FRAME     = HT * VT;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        fs;
        logic [15:0] fc;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        fs_p, fs_n;
    logic [15:0] fc_p, fc_n;

    vga_if vp ();
    vga_if vn ();

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1)
    ) dut_p (
        .clk(clk), .rst(rst), .en(en), .vga_out(vp),
        .frame_start(fs_p), .frame_cnt(fc_p)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .en(en), .vga_out(vn),
        .frame_start(fs_n), .frame_cnt(fc_n)
    );

    always #5 clk = ~clk;

    int   vectors    = 0;
    int   miscompares = 0;
    out_t sb_q[$];
    out_t m_exp;
    int   m_h = 0;
    int   m_v = 0;
    int   fs_seen = 0;
    int   vb_seen = 0;
    int   vs_seen = 0;

    // Scoreboard: pop one expectation per clock and compare both instances against it.
    always @(posedge clk) begin
        out_t e, en_exp, op, on;
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            en_exp = e;
            en_exp.hs = ~e.hs;
            en_exp.vs = ~e.vs;
            op = {vp.hcount, vp.vcount, vp.hsync, vp.vsync, vp.hblnk, vp.vblnk, vp.rgb, fs_p, fc_p};
            on = {vn.hcount, vn.vcount, vn.hsync, vn.vsync, vn.hblnk, vn.vblnk, vn.rgb, fs_n, fc_n};
            vectors = vectors + 2;
            if (op !== e) begin
                miscompares++;
                $display("FAIL sb_pos t=%0t got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h fs=%b fc=%0d exp h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h fs=%b fc=%0d",
                         $time, op.h, op.v, op.hs, op.vs, op.hb, op.vb, op.rgb, op.fs, op.fc,
                         e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb, e.fs, e.fc);
            end
            if (on !== en_exp) begin
                miscompares++;
                $display("FAIL sb_neg t=%0t got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b exp h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
                         $time, on.h, on.v, on.hs, on.vs, on.hb, on.vb, on.fs,
                         en_exp.h, en_exp.v, en_exp.hs, en_exp.vs, en_exp.hb, en_exp.vb, en_exp.fs);
            end
            if (fs_p === 1'b1) fs_seen++;
            if (vp.vblnk === 1'b1) vb_seen++;
            if (vp.vsync === 1'b1) vs_seen++;
        end
    end

    // Apply one cycle of stimulus and push the output the raster should show after the next edge.
    task automatic drive(input logic r, input logic e);
        logic wrap_frame;
        @(negedge clk);
        rst = r;
        en  = e;
        if (r) begin
            m_h = 0;
            m_v = 0;
            m_exp = '0;
        end else if (e) begin
            wrap_frame = (m_h == HT - 1) && (m_v == VT - 1);
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            m_exp.h  = 11'(m_h);
            m_exp.v  = 11'(m_v);
            m_exp.hb = (m_h >= HB_FIRST);
            m_exp.vb = (m_v >= VB_FIRST);
            m_exp.hs = (m_h >= HS_FIRST) && (m_h <= HS_LAST);
            m_exp.vs = (m_v >= VS_FIRST) && (m_v <= VS_LAST);
            m_exp.rgb = 12'h000;
            m_exp.fs = wrap_frame;
`ifdef VGA_FRAME_CNT_EN
            if (wrap_frame) m_exp.fc = m_exp.fc + 16'd1;
`endif
        end else begin
            m_exp.fs = 1'b0;
        end
        sb_q.push_back(m_exp);
    endtask

    // Wait until the last driven cycle is visible on the outputs.
    task automatic look();
        @(posedge clk);
        #3;
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(m_h == h && m_v == v) && n < 4 * FRAME) begin
            drive(1'b0, 1'b1);
            n++;
        end
        if (n >= 4 * FRAME) begin
            miscompares++;
            $display("FAIL run_to_timeout target h=%0d v=%0d reached h=%0d v=%0d", h, v, m_h, m_v);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        look();
        vectors++;
        if (vp.hcount !== 11'd0 || vp.vcount !== 11'd0 || vp.hsync !== 1'b0 || vn.hsync !== 1'b1
            || vp.hblnk !== 1'b0 || fs_p !== 1'b0 || fc_p !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state got h=%0d v=%0d hs=%b hsn=%b hb=%b fs=%b fc=%0d exp h=0 v=0 hs=0 hsn=1 hb=0 fs=0 fc=0",
                     vp.hcount, vp.vcount, vp.hsync, vn.hsync, vp.hblnk, fs_p, fc_p);
        end
    endtask

    task automatic test_line();
        drive(1'b1, 1'b0);
        for (int i = 0; i < HT; i++) drive(1'b0, 1'b1);
        look();
        vectors++;
        if (vp.hcount !== 11'd0 || vp.vcount !== 11'd1) begin
            miscompares++;
            $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=1", vp.hcount, vp.vcount);
        end
    endtask

    task automatic test_frame();
        drive(1'b1, 1'b0);
        fs_seen = 0;
        vb_seen = 0;
        vs_seen = 0;
        for (int i = 0; i < FRAME; i++) drive(1'b0, 1'b1);
        look();
        vectors = vectors + 3;
        if (fs_seen != 1) begin
            miscompares++;
            $display("FAIL frame_start_count got %0d exp 1", fs_seen);
        end
        if (vb_seen != (VT - VB_FIRST) * HT) begin
            miscompares++;
            $display("FAIL vblnk_cycles got %0d exp %0d", vb_seen, (VT - VB_FIRST) * HT);
        end
        if (vs_seen != (VS_LAST - VS_FIRST + 1) * HT) begin
            miscompares++;
            $display("FAIL vsync_cycles got %0d exp %0d", vs_seen, (VS_LAST - VS_FIRST + 1) * HT);
        end
    endtask

    task automatic test_enable_hold();
        run_to(20, 7);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
        look();
        vectors++;
        if (vp.hcount !== 11'd20 || vp.vcount !== 11'd7 || fs_p !== 1'b0) begin
            miscompares++;
            $display("FAIL en_hold got h=%0d v=%0d fs=%b exp h=20 v=7 fs=0", vp.hcount, vp.vcount, fs_p);
        end
        drive(1'b0, 1'b1);
        look();
        vectors++;
        if (vp.hcount !== 11'd21) begin
            miscompares++;
            $display("FAIL en_resume got h=%0d exp 21", vp.hcount);
        end
        // Stall right on the frame wrap: the pulse must drop while (0,0) is held.
        run_to(HT - 1, VT - 1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        look();
        vectors++;
        if (vp.hcount !== 11'd0 || vp.vcount !== 11'd0 || fs_p !== 1'b0) begin
            miscompares++;
            $display("FAIL en_hold_wrap got h=%0d v=%0d fs=%b exp h=0 v=0 fs=0", vp.hcount, vp.vcount, fs_p);
        end
        drive(1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        run_to(22, 11);
        look();
        vectors++;
        if (vp.hsync !== 1'b1 || vp.vsync !== 1'b1 || vn.hsync !== 1'b0 || vn.vsync !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_sync_active got hs=%b vs=%b hsn=%b vsn=%b exp 1 1 0 0",
                     vp.hsync, vp.vsync, vn.hsync, vn.vsync);
        end
        drive(1'b1, 1'b1);
        look();
        vectors++;
        if (vp.hcount !== 11'd0 || vp.vcount !== 11'd0 || vp.hsync !== 1'b0 || vp.vsync !== 1'b0
            || vn.hsync !== 1'b1 || vn.vsync !== 1'b1 || fs_p !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got h=%0d v=%0d hs=%b vs=%b hsn=%b vsn=%b fs=%b exp h=0 v=0 hs=0 vs=0 hsn=1 vsn=1 fs=0",
                     vp.hcount, vp.vcount, vp.hsync, vp.vsync, vn.hsync, vn.vsync, fs_p);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    endtask

    task automatic test_frame_cnt();
        logic [15:0] want;
        drive(1'b1, 1'b0);
        for (int i = 0; i < 3 * FRAME; i++) drive(1'b0, 1'b1);
        look();
`ifdef VGA_FRAME_CNT_EN
        want = 16'd3;
`else
        want = 16'd0;
`endif
        vectors++;
        if (fc_p !== want || fc_n !== want) begin
            miscompares++;
            $display("FAIL frame_cnt got %0d/%0d exp %0d", fc_p, fc_n, want);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
        end
        look();
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_enable_hold();
        test_reset_mid();
        test_frame_cnt();
        test_random();
        look();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain got %0d pending exp 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
